// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM initiator:
// FSM state encoding, default bus widths and wait-counter sizing.
package sram_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 48;

  localparam int ACCESS_MIN = 1;
  localparam int ACCESS_MAX = 15;

  // Wide enough to hold ACCESS_MAX-1.
  localparam int WAIT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WSETUP,
    WPULSE,
    WHOLD
  } state_e;

endpackage

// File: rtl/sram_ctrl.sv
// Single-word read/write initiator for the 48-bit asynchronous SRAM.
// Define SRAM_CTRL_POSTED_WRITE_EN to ack writes at acceptance instead of after WHOLD.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk_100mhz,
  input  logic              RSTN,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE,
  output logic              SRAM_OEN,
  output logic              SRAM_WEN,
  inout  wire  [DATA_W-1:0] SRAM_DQ
);

  if (ACCESS_CYCLES < ACCESS_MIN || ACCESS_CYCLES > ACCESS_MAX) begin : g_bad_access_cycles
    $error("sram_ctrl: ACCESS_CYCLES must lie in 1..15");
  end

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ACCESS_CYCLES - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_ack;
  logic                r_ce;
  logic                r_oen;
  logic                r_wen;
  logic                r_dq_oe;
  logic                w_accept;
  logic                w_sample;
  logic                w_ack_next;
  logic                w_ce_next;
  logic                w_oen_next;
  logic                w_wen_next;
  logic                w_dq_oe_next;

  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_wait  <= '0;
      r_ack   <= 1'b0;
      r_ce    <= 1'b1;
      r_oen   <= 1'b1;
      r_wen   <= 1'b1;
      r_dq_oe <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      r_ack   <= w_ack_next;
      r_ce    <= w_ce_next;
      r_oen   <= w_oen_next;
      r_wen   <= w_wen_next;
      r_dq_oe <= w_dq_oe_next;
      if (w_accept) begin
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      if (w_sample) begin
        r_rdata <= SRAM_DQ;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_ack_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          if (we) begin
            w_state_next = WSETUP;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
            w_ack_next   = 1'b1;
`endif
          end else begin
            w_state_next = READ;
            w_wait_next  = WAIT_LOAD;
          end
        end
      end
      READ: begin
        if (r_wait == '0) begin
          w_state_next = IDLE;
          w_sample     = 1'b1;
          w_ack_next   = 1'b1;
        end else begin
          w_wait_next = r_wait - 1'b1;
        end
      end
      WSETUP: begin
        w_state_next = WPULSE;
        w_wait_next  = WAIT_LOAD;
      end
      WPULSE: begin
        if (r_wait == '0) begin
          w_state_next = WHOLD;
        end else begin
          w_wait_next = r_wait - 1'b1;
        end
      end
      WHOLD: begin
        w_state_next = IDLE;
`ifndef SRAM_CTRL_POSTED_WRITE_EN
        w_ack_next   = 1'b1;
`endif
      end
      default: w_state_next = IDLE;
    endcase

    // Pins are decoded from the next state so they change cleanly on the clock edge.
    w_ce_next    = (w_state_next == IDLE);
    w_oen_next   = (w_state_next != READ);
    w_wen_next   = (w_state_next != WPULSE);
    w_dq_oe_next = (w_state_next == WSETUP) || (w_state_next == WPULSE) ||
                   (w_state_next == WHOLD);
  end

  assign ready     = (r_state == IDLE);
  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign SRAM_ADDR = r_addr;
  assign SRAM_CE   = r_ce;
  assign SRAM_OEN  = r_oen;
  assign SRAM_WEN  = r_wen;
  assign SRAM_DQ   = r_dq_oe ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: SRAM device model, cycle-level reference
// model with a per-cycle compare process, directed scenarios and random traffic.
module tb_sram_ctrl;

  localparam int AW = 20;
  localparam int DW = 48;
`ifdef SRAM_CTRL_POSTED_WRITE_EN
  localparam int A      = 1;
  localparam bit POSTED = 1'b1;
`else
  localparam int A      = 2;
  localparam bit POSTED = 1'b0;
`endif

  logic          clk_100mhz = 1'b0;
  logic          RSTN = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ready;
  logic          ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] SRAM_ADDR;
  logic          SRAM_CE;
  logic          SRAM_OEN;
  logic          SRAM_WEN;
  wire  [DW-1:0] SRAM_DQ;

  int checks = 0;
  int errors = 0;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(A)) dut (
    .clk_100mhz(clk_100mhz), .RSTN(RSTN), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ready(ready), .ack(ack), .rdata(rdata),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_CE(SRAM_CE), .SRAM_OEN(SRAM_OEN),
    .SRAM_WEN(SRAM_WEN), .SRAM_DQ(SRAM_DQ)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return {8'hA5, a, a};
  endfunction

  // SRAM device plus bench bus-hold: bench drives the bus whenever the DUT must not.
  logic [DW-1:0] dev_mem [logic [AW-1:0]];
  logic [DW-1:0] dev_rd = '0;
  logic          m_wr_act = 1'b0;
  assign SRAM_DQ = m_wr_act ? {DW{1'bz}} : ((!SRAM_CE && !SRAM_OEN) ? dev_rd : '0);

  initial forever begin
    @(posedge clk_100mhz);
    #1;
    dev_rd = dev_mem.exists(SRAM_ADDR) ? dev_mem[SRAM_ADDR] : pattern(SRAM_ADDR);
  end

  initial forever begin
    @(negedge clk_100mhz);
    if (RSTN && !SRAM_CE && !SRAM_WEN) dev_mem[SRAM_ADDR] = SRAM_DQ;
  end

  // Reference model: one transaction record and the timing rules as arithmetic on cycle offsets.
  typedef struct packed {
    logic ready, ack, ce, oen, wen, act, wr_act, rd_act;
  } exp_t;

  logic [DW-1:0] mdl_mem [logic [AW-1:0]];
  int            cyc = 0;
  bit            have = 1'b0;
  bit            t_wr = 1'b0;
  int            t0 = 0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_data = '0;
  logic [DW-1:0] t_exp = '0;
  logic [DW-1:0] m_rdata = '0;

  function automatic exp_t calc(input int c);
    exp_t e;
    int   k;
    int   len;
    e = '0;
    e.ready = 1'b1; e.ce = 1'b1; e.oen = 1'b1; e.wen = 1'b1;
    if (have) begin
      k   = c - t0;
      len = t_wr ? A + 3 : A + 1;
      if (k >= 1 && k < len) begin
        e.ready = 1'b0; e.ce = 1'b0; e.act = 1'b1;
        if (t_wr) begin
          e.wr_act = 1'b1;
          if (k >= 2 && k <= A + 1) e.wen = 1'b0;
        end else begin
          e.rd_act = 1'b1;
          e.oen    = 1'b0;
        end
      end
      if ((t_wr && POSTED) ? (k == 1) : (k == len)) e.ack = 1'b1;
    end
    return e;
  endfunction

  initial begin
    exp_t cur;
    forever begin
      @(posedge clk_100mhz or negedge RSTN);
      if (!RSTN) begin
        have    = 1'b0;
        m_rdata = '0;
      end else begin
        cur = calc(cyc);
        if (cur.ready && req) begin
          have   = 1'b1;
          t_wr   = we;
          t0     = cyc;
          t_addr = addr;
          t_data = wdata;
          if (we) mdl_mem[addr] = wdata;
          else t_exp = mdl_mem.exists(addr) ? mdl_mem[addr] : pattern(addr);
        end
        cyc++;
        cur = calc(cyc);
        if (cur.ack && !t_wr) m_rdata = t_exp;
      end
      cur = calc(cyc);
      m_wr_act = cur.wr_act;
    end
  end

  // Per-cycle compare process.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_100mhz);
      if (!RSTN) begin
        chk("rst_ready", DW'(ready), DW'(1'b1));
        chk("rst_ack", DW'(ack), DW'(1'b0));
        chk("rst_ce", DW'(SRAM_CE), DW'(1'b1));
        chk("rst_oen", DW'(SRAM_OEN), DW'(1'b1));
        chk("rst_wen", DW'(SRAM_WEN), DW'(1'b1));
        chk("rst_addr", DW'(SRAM_ADDR), '0);
        chk("rst_rdata", rdata, '0);
      end else begin
        e = calc(cyc);
        chk("cyc_ready", DW'(ready), DW'(e.ready));
        chk("cyc_ack", DW'(ack), DW'(e.ack));
        chk("cyc_ce", DW'(SRAM_CE), DW'(e.ce));
        chk("cyc_oen", DW'(SRAM_OEN), DW'(e.oen));
        chk("cyc_wen", DW'(SRAM_WEN), DW'(e.wen));
        chk("cyc_dq", SRAM_DQ, e.wr_act ? t_data : (e.rd_act ? t_exp : '0));
        chk("cyc_rdata", rdata, m_rdata);
        if (e.act) chk("cyc_addr", DW'(SRAM_ADDR), DW'(t_addr));
      end
    end
  end

  // Call at a negedge; returns at the negedge of cycle 1 with req dropped.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    req = 1'b1; we = w; addr = a; wdata = d;
    while (!ready && n < 50) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("accept_ready", DW'(ready), DW'(1'b1));
    @(negedge clk_100mhz);
    req = 1'b0;
  endtask

  task automatic wait_ack(output int k);
    k = 1;
    while (!ack && k < 40) begin
      @(negedge clk_100mhz);
      k++;
    end
    chk("ack_seen", DW'(ack), DW'(1'b1));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("idle_ready", DW'(ready), DW'(1'b1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] pool [8];

  initial begin
    int wen_low, ack_at, rdy_at, k, acks, n;
    pool = '{20'h00010, 20'h80005, 20'h00042, 20'hFFFFF,
             20'h00000, 20'h12345, 20'h54321, 20'hABCDE};
    dev_mem[20'h00010] = 48'h123456789ABC;
    mdl_mem[20'h00010] = 48'h123456789ABC;

    #1 RSTN = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    chk("reset_ready", DW'(ready), DW'(1'b1));
    chk("reset_rdata", rdata, '0);
    chk("reset_addr", DW'(SRAM_ADDR), '0);
    RSTN = 1'b1;
    @(negedge clk_100mhz);

    // Single read of a preloaded word.
    issue(1'b0, 20'h00010, '0);
    chk("t1_ready_c1", DW'(ready), DW'(1'b0));
    chk("t1_ce_c1", DW'(SRAM_CE), DW'(1'b0));
    chk("t1_oen_c1", DW'(SRAM_OEN), DW'(1'b0));
    for (int c = 2; c <= A; c++) begin
      @(negedge clk_100mhz);
      chk("t1_ce_active", DW'(SRAM_CE), DW'(1'b0));
      chk("t1_oen_active", DW'(SRAM_OEN), DW'(1'b0));
    end
    @(negedge clk_100mhz);
    chk("t1_ack", DW'(ack), DW'(1'b1));
    chk("t1_rdata", rdata, 48'h123456789ABC);

    // Write then read back.
    issue(1'b1, 20'h80005, 48'hDEADBEEF0001);
    wen_low = 0; ack_at = 0; rdy_at = 0;
    for (int c = 1; c <= A + 3; c++) begin
      if (c > 1) @(negedge clk_100mhz);
      if (!SRAM_WEN) wen_low++;
      if (ack && ack_at == 0) ack_at = c;
      if (ready && rdy_at == 0) rdy_at = c;
    end
    chk("t2_wen_low_cycles", DW'(wen_low), DW'(A));
    chk("t2_ack_cycle", DW'(ack_at), POSTED ? DW'(1) : DW'(A + 3));
    chk("t2_ready_cycle", DW'(rdy_at), DW'(A + 3));
    issue(1'b0, 20'h80005, '0);
    wait_ack(k);
    chk("t2_rd_ack_cycle", DW'(k), DW'(A + 1));
    chk("t2_readback", rdata, 48'hDEADBEEF0001);

    // Back-to-back reads with req held high.
    req = 1'b1; we = 1'b0; addr = 20'h00010;
    acks = 0; n = 0;
    while (acks < 3 && n < 60) begin
      @(negedge clk_100mhz);
      n++;
      if (ack) acks++;
    end
    req = 1'b0;
    chk("t3_cycles_3_reads", DW'(n), DW'(3 * (A + 1)));
    chk("t3_rdata", rdata, 48'h123456789ABC);

    // Address toggled while a write is in flight.
    req = 1'b1; we = 1'b1; addr = 20'h00042; wdata = 48'h000042424242;
    acks = 0; n = 0;
    do begin
      @(negedge clk_100mhz);
      n++;
      if (ack) acks++;
      if (!ready) chk("t4_addr_latched", DW'(SRAM_ADDR), DW'(20'h00042));
      addr = AW'($urandom);
    end while (!ready && n < 40);
    req = 1'b0;
    chk("t4_ack_count", DW'(acks), DW'(1));
    issue(1'b0, 20'h00042, '0);
    wait_ack(k);
    chk("t4_readback", rdata, 48'h000042424242);

    // Reset asserted between edges during WPULSE.
    issue(1'b1, 20'h7ABCD, 48'hCAFEF00D1234);
    @(posedge clk_100mhz);
    if (A >= 2) @(posedge clk_100mhz);
    #2 RSTN = 1'b0;
    #1;
    chk("t5_ce", DW'(SRAM_CE), DW'(1'b1));
    chk("t5_oen", DW'(SRAM_OEN), DW'(1'b1));
    chk("t5_wen", DW'(SRAM_WEN), DW'(1'b1));
    chk("t5_dq_released", SRAM_DQ, '0);
    chk("t5_ack", DW'(ack), DW'(1'b0));
    @(negedge clk_100mhz);
    RSTN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_100mhz);
      chk("t5_no_ack", DW'(ack), DW'(1'b0));
      chk("t5_ready", DW'(ready), DW'(1'b1));
    end

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 200; i++) begin
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      repeat ($urandom_range(0, 2)) @(negedge clk_100mhz);
      w = 1'($urandom_range(0, 1));
      a = pool[$urandom_range(0, 7)];
      d = {16'($urandom), 32'($urandom)};
      issue(w, a, d);
      wait_ready();
    end

    repeat (4) @(negedge clk_100mhz);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
